// File: rtl/pi_code_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pi_code_ctrl
// Brief    : CDR loop controller. Bang-bang votes are accumulated over fixed
//            windows and fed to a 2nd-order filter that steers a wrapping PI code.
// Revision : 1.0  initial release
// ============================================================================
module pi_code_ctrl #(
  parameter int CODE_W    = 11,
  parameter int WIN       = 16,
  parameter int KP        = 4,
  parameter int KI_SHIFT  = 4,
  parameter int FREQ_W    = 16,
  parameter int LOCK_CNT  = 32,
  parameter int INIT_CODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     vote_valid,
  input  logic                     vote_up,
  input  logic                     vote_dn,
  input  logic                     freeze,
  input  logic                     load,
  input  logic [CODE_W-1:0]        load_code,
  output logic [CODE_W-1:0]        pi_code,
  output logic                     code_upd,
  output logic signed [FREQ_W-1:0] freq_acc,
  output logic                     locked
);

  localparam int c_NET_W  = $clog2(WIN) + 2;
  localparam int c_CNT_W  = $clog2(WIN);
  localparam int c_LCK_W  = $clog2(LOCK_CNT + 1);
  localparam int c_BASE_W = (FREQ_W > CODE_W) ? FREQ_W : CODE_W;
  localparam int c_STEP_W = c_BASE_W + $clog2(KP + 1) + 2;

  localparam logic [CODE_W-1:0]          c_INIT     = CODE_W'(INIT_CODE);
  localparam logic signed [FREQ_W:0]     c_FMAX     = (FREQ_W+1)'(2**(FREQ_W-1) - 1);
  localparam logic signed [FREQ_W:0]     c_FMIN     = -c_FMAX;
  localparam logic signed [c_STEP_W-1:0] c_KP       = c_STEP_W'(KP);
  localparam logic [c_NET_W-1:0]         c_QTR      = c_NET_W'(WIN / 4);
  localparam logic [c_NET_W-1:0]         c_HALF     = c_NET_W'(WIN / 2);
  localparam logic [c_CNT_W-1:0]         c_LAST     = c_CNT_W'(WIN - 1);
  localparam logic [c_LCK_W-1:0]         c_LCK_MAX  = c_LCK_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t                     r_state, w_state_nx;
  logic [CODE_W-1:0]          r_pi_code, w_code_nx;
  logic signed [FREQ_W-1:0]   r_freq, w_freq_nx;
  logic                       r_upd, w_upd_nx;
  logic                       r_locked, w_locked_nx;
  logic signed [c_NET_W-1:0]  r_net, w_net_nx;
  logic [c_CNT_W-1:0]         r_cnt, w_cnt_nx;
  logic [c_LCK_W-1:0]         r_lcnt, w_lcnt_nx;

  logic signed [c_NET_W-1:0]  w_delta;
  logic signed [1:0]          w_dir;
  logic [c_NET_W-1:0]         w_abs;
  logic signed [FREQ_W:0]     w_fsum;
  logic signed [FREQ_W-1:0]   w_freq_n;
  logic signed [c_STEP_W-1:0] w_fext;
  logic signed [c_STEP_W-1:0] w_kp_term;
  logic signed [c_STEP_W-1:0] w_step;
  logic [CODE_W-1:0]          w_code_sum;
  logic [c_LCK_W-1:0]         w_lcnt_inc;

  // Loop-filter datapath, consumed only in the UPDATE cycle.
  always_comb begin
    w_delta = '0;
    if (vote_up && !vote_dn)
      w_delta = c_NET_W'(1);
    else if (vote_dn && !vote_up)
      w_delta = '1;

    w_dir = 2'sd0;
    if (r_net[c_NET_W-1])
      w_dir = -2'sd1;
    else if (r_net != '0)
      w_dir = 2'sd1;

    w_abs  = r_net[c_NET_W-1] ? c_NET_W'(-r_net) : c_NET_W'(r_net);
    w_fsum = $signed({r_freq[FREQ_W-1], r_freq}) + $signed({{(FREQ_W-1){w_dir[1]}}, w_dir});

    w_freq_n = w_fsum[FREQ_W-1:0];
    if (w_fsum > c_FMAX)
      w_freq_n = c_FMAX[FREQ_W-1:0];
    else if (w_fsum < c_FMIN)
      w_freq_n = c_FMIN[FREQ_W-1:0];

    w_fext    = {{(c_STEP_W-FREQ_W){w_freq_n[FREQ_W-1]}}, w_freq_n};
    w_kp_term = '0;
    if (w_dir == 2'sd1)
      w_kp_term = c_KP;
    else if (w_dir == -2'sd1)
      w_kp_term = -c_KP;

    w_step     = w_kp_term + (w_fext >>> KI_SHIFT);
    w_code_sum = r_pi_code + w_step[CODE_W-1:0];
    w_lcnt_inc = (r_lcnt == c_LCK_MAX) ? r_lcnt : r_lcnt + c_LCK_W'(1);
  end

  always_comb begin
    w_state_nx  = r_state;
    w_code_nx   = r_pi_code;
    w_freq_nx   = r_freq;
    w_upd_nx    = 1'b0;
    w_locked_nx = r_locked;
    w_net_nx    = r_net;
    w_cnt_nx    = r_cnt;
    w_lcnt_nx   = r_lcnt;

    if (!en) begin
      w_state_nx  = S_IDLE;
      w_net_nx    = '0;
      w_cnt_nx    = '0;
      w_lcnt_nx   = '0;
      w_locked_nx = 1'b0;
      if (load) begin
        w_code_nx = load_code;
        w_upd_nx  = 1'b1;
      end
    end else if (load) begin
      w_state_nx  = S_COLLECT;
      w_code_nx   = load_code;
      w_freq_nx   = '0;
      w_upd_nx    = 1'b1;
      w_net_nx    = '0;
      w_cnt_nx    = '0;
      w_lcnt_nx   = '0;
      w_locked_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = S_COLLECT;
        S_COLLECT: begin
          if (vote_valid && !freeze) begin
            w_net_nx = r_net + w_delta;
            w_cnt_nx = r_cnt + c_CNT_W'(1);
            if (r_cnt == c_LAST)
              w_state_nx = S_UPDATE;
          end
        end
        S_UPDATE: begin
          w_state_nx = S_COLLECT;
          w_freq_nx  = w_freq_n;
          w_code_nx  = w_code_sum;
          w_upd_nx   = (w_step != '0);
          w_net_nx   = '0;
          w_cnt_nx   = '0;
          w_lcnt_nx  = (w_abs <= c_QTR) ? w_lcnt_inc : '0;
          if (w_lcnt_nx >= c_LCK_MAX)
            w_locked_nx = 1'b1;
          // Large error drops lock at once; mid-size error only restarts the count.
          if (w_abs > c_HALF)
            w_locked_nx = 1'b0;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pi_code <= c_INIT;
      r_freq    <= '0;
      r_upd     <= 1'b0;
      r_locked  <= 1'b0;
      r_net     <= '0;
      r_cnt     <= '0;
      r_lcnt    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pi_code <= w_code_nx;
      r_freq    <= w_freq_nx;
      r_upd     <= w_upd_nx;
      r_locked  <= w_locked_nx;
      r_net     <= w_net_nx;
      r_cnt     <= w_cnt_nx;
      r_lcnt    <= w_lcnt_nx;
    end
  end

  assign pi_code  = r_pi_code;
  assign code_upd = r_upd;
  assign freq_acc = r_freq;
  assign locked   = r_locked;

endmodule
`default_nettype wire
